// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing for the five-stage core: boot hold, load-use stall, branch flush,
// operand forwarding selects and saturating stall/flush event counters.
//
// state   | meaning
// ST_BOOT | post-reset hold: PC frozen, IF/ID flushed, NOPs into ID/EXE, no forwarding
// ST_RUN  | normal issue; load-use hazard stalls, taken branch flushes IF/ID
module pipe_hazard_ctrl #(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [3:0]       id_ra_i,
    input  logic [3:0]       id_rb_i,
    input  logic [3:0]       id_rd_i,
    input  logic             id_use_a_i,
    input  logic             id_use_b_i,
    input  logic             id_use_d_i,
    input  logic             id_branch_taken_i,
    input  logic [3:0]       ex_rd_i,
    input  logic             ex_rf_en_i,
    input  logic             ex_load_i,
    input  logic [3:0]       mem_rd_i,
    input  logic             mem_rf_en_i,
    input  logic [3:0]       wb_rd_i,
    input  logic             wb_rf_en_i,
    input  logic             clear_counters_i,
    output logic             pc_load_enable_o,
    output logic             ifid_load_enable_o,
    output logic             ifid_reset_o,
    output logic             idex_mux_control_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [1:0]       fwd_d_o,
    output logic [CNT_W-1:0] stall_count_o,
    output logic [CNT_W-1:0] flush_count_o,
    output logic             booting_o
);

    typedef enum logic {ST_BOOT, ST_RUN} state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       boot_cnt_q, boot_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hazard;
    logic             stall_inc, flush_inc;

    // r15 is the hardwired register and never creates a dependency.
    assign hazard = ex_load_i & ex_rf_en_i & (ex_rd_i != 4'd15) &
                    ((id_use_a_i & (id_ra_i == ex_rd_i)) |
                     (id_use_b_i & (id_rb_i == ex_rd_i)) |
                     (id_use_d_i & (id_rd_i == ex_rd_i)));

    function automatic logic [1:0] fwd_sel(input logic use_f, input logic [3:0] r,
                                           input logic [3:0] ex_rd, input logic ex_fwd_ok,
                                           input logic [3:0] mem_rd, input logic mem_en,
                                           input logic [3:0] wb_rd, input logic wb_en);
        logic [1:0] sel;
        sel = 2'd0;
        if (use_f && r != 4'd15) begin
            if (ex_fwd_ok && ex_rd == r)      sel = 2'd1;
            else if (mem_en && mem_rd == r)   sel = 2'd2;
            else if (wb_en && wb_rd == r)     sel = 2'd3;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a_o = 2'd0;
        fwd_b_o = 2'd0;
        fwd_d_o = 2'd0;
        if (state_q == ST_RUN) begin
            fwd_a_o = fwd_sel(id_use_a_i, id_ra_i, ex_rd_i, ex_rf_en_i & ~ex_load_i,
                              mem_rd_i, mem_rf_en_i, wb_rd_i, wb_rf_en_i);
            fwd_b_o = fwd_sel(id_use_b_i, id_rb_i, ex_rd_i, ex_rf_en_i & ~ex_load_i,
                              mem_rd_i, mem_rf_en_i, wb_rd_i, wb_rf_en_i);
            fwd_d_o = fwd_sel(id_use_d_i, id_rd_i, ex_rd_i, ex_rf_en_i & ~ex_load_i,
                              mem_rd_i, mem_rf_en_i, wb_rd_i, wb_rf_en_i);
        end
    end

    always_comb begin
        state_d            = state_q;
        boot_cnt_d         = boot_cnt_q;
        pc_load_enable_o   = 1'b1;
        ifid_load_enable_o = 1'b1;
        ifid_reset_o       = 1'b0;
        idex_mux_control_o = 1'b0;
        booting_o          = 1'b0;
        stall_inc          = 1'b0;
        flush_inc          = 1'b0;
        case (state_q)
            ST_BOOT: begin
                pc_load_enable_o   = 1'b0;
                ifid_reset_o       = 1'b1;
                idex_mux_control_o = 1'b1;
                booting_o          = 1'b1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d    = ST_RUN;
                    boot_cnt_d = 4'd0;
                end else begin
                    boot_cnt_d = boot_cnt_q + 4'd1;
                end
            end
            ST_RUN: begin
                // Stall beats flush: the branch stays in ID and is re-evaluated next cycle.
                if (hazard) begin
                    pc_load_enable_o   = 1'b0;
                    ifid_load_enable_o = 1'b0;
                    idex_mux_control_o = 1'b1;
                    stall_inc          = 1'b1;
                end else if (id_branch_taken_i) begin
                    ifid_reset_o = 1'b1;
                    flush_inc    = 1'b1;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clear_counters_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush_inc && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_BOOT;
            boot_cnt_q  <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count_o = stall_cnt_q;
    assign flush_count_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with BOOT_CYCLES=2 and CNT_W=4 so saturation is reachable.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic [3:0]       id_ra_i, id_rb_i, id_rd_i;
    logic             id_use_a_i, id_use_b_i, id_use_d_i, id_branch_taken_i;
    logic [3:0]       ex_rd_i, mem_rd_i, wb_rd_i;
    logic             ex_rf_en_i, ex_load_i, mem_rf_en_i, wb_rf_en_i;
    logic             clear_counters_i;
    logic             pc_load_enable_o, ifid_load_enable_o, ifid_reset_o, idex_mux_control_o;
    logic [1:0]       fwd_a_o, fwd_b_o, fwd_d_o;
    logic [CNT_W-1:0] stall_count_o, flush_count_o;
    logic             booting_o;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_hazard_ctrl #(.BOOT_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .id_ra_i(id_ra_i), .id_rb_i(id_rb_i), .id_rd_i(id_rd_i),
        .id_use_a_i(id_use_a_i), .id_use_b_i(id_use_b_i), .id_use_d_i(id_use_d_i),
        .id_branch_taken_i(id_branch_taken_i),
        .ex_rd_i(ex_rd_i), .ex_rf_en_i(ex_rf_en_i), .ex_load_i(ex_load_i),
        .mem_rd_i(mem_rd_i), .mem_rf_en_i(mem_rf_en_i),
        .wb_rd_i(wb_rd_i), .wb_rf_en_i(wb_rf_en_i),
        .clear_counters_i(clear_counters_i),
        .pc_load_enable_o(pc_load_enable_o), .ifid_load_enable_o(ifid_load_enable_o),
        .ifid_reset_o(ifid_reset_o), .idex_mux_control_o(idex_mux_control_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .fwd_d_o(fwd_d_o),
        .stall_count_o(stall_count_o), .flush_count_o(flush_count_o),
        .booting_o(booting_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle_inputs();
        id_ra_i = 4'd0; id_rb_i = 4'd0; id_rd_i = 4'd0;
        id_use_a_i = 1'b0; id_use_b_i = 1'b0; id_use_d_i = 1'b0;
        id_branch_taken_i = 1'b0;
        ex_rd_i = 4'd0; ex_rf_en_i = 1'b0; ex_load_i = 1'b0;
        mem_rd_i = 4'd0; mem_rf_en_i = 1'b0;
        wb_rd_i = 4'd0; wb_rf_en_i = 1'b0;
        clear_counters_i = 1'b0;
    endtask

    task automatic load_use_r3();
        ex_load_i = 1'b1; ex_rf_en_i = 1'b1; ex_rd_i = 4'd3;
        id_ra_i = 4'd3; id_use_a_i = 1'b1;
    endtask

    initial begin
        rst_n_i = 1'b0;
        idle_inputs();
        // Hazard and forwarding opportunity present throughout reset and boot.
        ex_load_i = 1'b1; ex_rf_en_i = 1'b1; ex_rd_i = 4'd2;
        id_ra_i = 4'd2; id_use_a_i = 1'b1;
        mem_rd_i = 4'd2; mem_rf_en_i = 1'b1;
        repeat (3) tick();
        #1;
        chk("rst_booting", booting_o, 1);
        chk("rst_pc_le", pc_load_enable_o, 0);
        chk("rst_ifid_le", ifid_load_enable_o, 1);
        chk("rst_ifid_reset", ifid_reset_o, 1);
        chk("rst_idex_mux", idex_mux_control_o, 1);
        chk("rst_fwd_a", fwd_a_o, 0);
        chk("rst_stall_cnt", stall_count_o, 0);

        rst_n_i = 1'b1;
        tick(); #1;
        chk("boot1_booting", booting_o, 1);
        chk("boot1_pc_le", pc_load_enable_o, 0);
        chk("boot1_fwd_a", fwd_a_o, 0);
        tick();
        idle_inputs();
        #1;
        chk("run_booting", booting_o, 0);
        chk("run_pc_le", pc_load_enable_o, 1);
        chk("run_ifid_reset", ifid_reset_o, 0);
        chk("boot_stall_cnt", stall_count_o, 0);
        chk("boot_flush_cnt", flush_count_o, 0);

        // Load-use on operand A, then the load moves to MEM.
        load_use_r3();
        #1;
        chk("lu_pc_le", pc_load_enable_o, 0);
        chk("lu_ifid_le", ifid_load_enable_o, 0);
        chk("lu_idex_mux", idex_mux_control_o, 1);
        chk("lu_ifid_reset", ifid_reset_o, 0);
        chk("lu_fwd_a_no_ex", fwd_a_o, 0);
        tick();
        chk("lu_stall_cnt", stall_count_o, 1);
        ex_load_i = 1'b0; ex_rf_en_i = 1'b0; mem_rd_i = 4'd3; mem_rf_en_i = 1'b1;
        #1;
        chk("lu_after_pc_le", pc_load_enable_o, 1);
        chk("lu_after_fwd_a", fwd_a_o, 2);

        // Hazard variants: r15 never stalls, store-data source does.
        idle_inputs();
        ex_load_i = 1'b1; ex_rf_en_i = 1'b1; ex_rd_i = 4'd15;
        id_ra_i = 4'd15; id_use_a_i = 1'b1;
        #1;
        chk("r15_no_stall", pc_load_enable_o, 1);
        ex_rd_i = 4'd7; id_ra_i = 4'd0; id_rd_i = 4'd7; id_use_d_i = 1'b1;
        #1;
        chk("lu_d_idex_mux", idex_mux_control_o, 1);
        id_use_d_i = 1'b0;
        #1;
        chk("lu_d_unused", idex_mux_control_o, 0);

        // Forwarding priority on operand B.
        idle_inputs();
        id_rb_i = 4'd5; id_use_b_i = 1'b1;
        ex_rd_i = 4'd5; ex_rf_en_i = 1'b1;
        mem_rd_i = 4'd5; mem_rf_en_i = 1'b1;
        wb_rd_i = 4'd5; wb_rf_en_i = 1'b1;
        #1; chk("fwd_b_ex", fwd_b_o, 1);
        ex_rf_en_i = 1'b0;
        #1; chk("fwd_b_mem", fwd_b_o, 2);
        mem_rf_en_i = 1'b0;
        #1; chk("fwd_b_wb", fwd_b_o, 3);
        id_rb_i = 4'd15;
        #1; chk("fwd_b_r15", fwd_b_o, 0);
        id_rd_i = 4'd5;
        #1; chk("fwd_d_unused", fwd_d_o, 0);
        id_use_d_i = 1'b1;
        #1; chk("fwd_d_wb", fwd_d_o, 3);

        // Branch together with a stall, then alone.
        idle_inputs();
        load_use_r3();
        id_branch_taken_i = 1'b1;
        #1;
        chk("br_stall_ifid_reset", ifid_reset_o, 0);
        chk("br_stall_pc_le", pc_load_enable_o, 0);
        tick();
        chk("br_stall_flush_cnt", flush_count_o, 0);
        chk("br_stall_stall_cnt", stall_count_o, 2);
        ex_load_i = 1'b0; ex_rf_en_i = 1'b0;
        #1;
        chk("br_ifid_reset", ifid_reset_o, 1);
        chk("br_pc_le", pc_load_enable_o, 1);
        tick();
        chk("br_flush_cnt", flush_count_o, 1);
        chk("br_stall_cnt_hold", stall_count_o, 2);

        // Saturation of the stall counter, then clear with the hazard still present.
        idle_inputs();
        load_use_r3();
        repeat (20) tick();
        chk("sat_stall_cnt", stall_count_o, 15);
        clear_counters_i = 1'b1;
        tick();
        chk("clr_stall_cnt", stall_count_o, 0);
        chk("clr_flush_cnt", flush_count_o, 0);
        clear_counters_i = 1'b0;

        // Asynchronous reset in the middle of a stall.
        id_rb_i = 4'd2; id_use_b_i = 1'b1; mem_rd_i = 4'd2; mem_rf_en_i = 1'b1;
        tick();
        chk("pre_rst_stall_cnt", stall_count_o, 1);
        chk("pre_rst_fwd_b", fwd_b_o, 2);
        rst_n_i = 1'b0;
        #1;
        chk("mid_rst_booting", booting_o, 1);
        chk("mid_rst_pc_le", pc_load_enable_o, 0);
        chk("mid_rst_fwd_b", fwd_b_o, 0);
        chk("mid_rst_stall_cnt", stall_count_o, 0);
        chk("mid_rst_flush_cnt", flush_count_o, 0);
        tick();
        idle_inputs();
        rst_n_i = 1'b1;
        tick(); #1;
        chk("reboot1_booting", booting_o, 1);
        tick(); #1;
        chk("reboot_run_booting", booting_o, 0);
        chk("reboot_run_pc_le", pc_load_enable_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
